// File: rtl/seq_divider_if.sv
// Start/Busy/Done handshake and operand/result bundle for seq_divider.
// The control unit drives the master side; the divider implements the slave side.
interface seq_divider_if #(
  parameter int unsigned NrOfBits = 32
);
  logic                Start;
  logic                Signed;
  logic [NrOfBits-1:0] DataA;
  logic [NrOfBits-1:0] DataB;
  logic                Busy;
  logic                Done;
  logic [NrOfBits-1:0] Quotient;
  logic [NrOfBits-1:0] Remainder;
  logic                DivByZero;

  modport master (
    output Start, Signed, DataA, DataB,
    input  Busy, Done, Quotient, Remainder, DivByZero
  );

  modport slave (
    input  Start, Signed, DataA, DataB,
    output Busy, Done, Quotient, Remainder, DivByZero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one trial subtraction per clock, RISC-V M semantics.
// Fixed latency of NrOfBits+1 cycles from the Start capture edge to the Done pulse.
module seq_divider #(
    parameter int unsigned NrOfBits = 32
) (
    input logic         Clock,
    input logic         ResetN,
    seq_divider_if.slave bus
);
    localparam int unsigned CntW = (NrOfBits > 2) ? $clog2(NrOfBits) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic                b_zero_q, b_zero_d;
    logic [NrOfBits-1:0] dividend_q, dividend_d;
    logic [NrOfBits-1:0] divisor_q, divisor_d;
    logic [NrOfBits:0]   rem_q, rem_d;
    logic [NrOfBits-1:0] quotient_q, quotient_d;
    logic [NrOfBits-1:0] remainder_q, remainder_d;
    logic                div_by_zero_q, div_by_zero_d;
    logic                done_q, done_d;

    logic                a_neg, b_neg;
    logic [NrOfBits+1:0] shift_full;
    logic [NrOfBits+1:0] trial;
    logic                borrow;

    assign a_neg = bus.Signed & bus.DataA[NrOfBits-1];
    assign b_neg = bus.Signed & bus.DataB[NrOfBits-1];

    // Partial remainder with the next dividend bit shifted in; the trial
    // subtraction is one bit wider so its MSB is the borrow.
    assign shift_full = {rem_q, dividend_q[NrOfBits-1]};
    assign trial      = shift_full - {2'b00, divisor_q};
    assign borrow     = trial[NrOfBits+1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        b_zero_d      = b_zero_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        rem_d         = rem_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    sign_a_d   = a_neg;
                    sign_b_d   = b_neg;
                    b_zero_d   = (bus.DataB == '0);
                    dividend_d = a_neg ? (~bus.DataA + 1'b1) : bus.DataA;
                    divisor_d  = b_neg ? (~bus.DataB + 1'b1) : bus.DataB;
                    rem_d      = '0;
                    cnt_d      = '0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (borrow) begin
                    rem_d      = shift_full[NrOfBits:0];
                    dividend_d = {dividend_q[NrOfBits-2:0], 1'b0};
                end else begin
                    rem_d      = trial[NrOfBits:0];
                    dividend_d = {dividend_q[NrOfBits-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(NrOfBits - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                // With a zero divisor every step subtracts nothing, so the
                // remainder is |DataA| and re-applying the sign restores DataA.
                if (b_zero_q) begin
                    quotient_d = '1;
                end else if (sign_a_q ^ sign_b_q) begin
                    quotient_d = ~dividend_q + 1'b1;
                end else begin
                    quotient_d = dividend_q;
                end
                remainder_d   = sign_a_q ? (~rem_q[NrOfBits-1:0] + 1'b1)
                                         : rem_q[NrOfBits-1:0];
                div_by_zero_d = b_zero_q;
                done_d        = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            b_zero_q      <= 1'b0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            rem_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            b_zero_q      <= b_zero_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            rem_q         <= rem_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            done_q        <= done_d;
        end
    end

    assign bus.Busy      = (state_q != IDLE);
    assign bus.Done      = done_q;
    assign bus.Quotient  = quotient_q;
    assign bus.Remainder = remainder_q;
    assign bus.DivByZero = div_by_zero_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (N=32): result table plus handshake,
// back-to-back and mid-operation reset sequences.
module tb_seq_divider;
    localparam int unsigned N   = 32;
    localparam int unsigned LAT = N + 1;

    logic Clock;
    logic ResetN;
    int   checks;
    int   errors;

    seq_divider_if #(.NrOfBits(N)) bus_if ();

    seq_divider #(.NrOfBits(N)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus_if)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive operands with Start for one capture edge, then sample #1 after it.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clock);
        bus_if.Start  = 1'b1;
        bus_if.Signed = sgn;
        bus_if.DataA  = a;
        bus_if.DataB  = b;
        @(posedge Clock);
        #1;
        bus_if.Start  = 1'b0;
    endtask

    // Count edges from the capture edge until Done, checking Busy on the way.
    task automatic wait_done(input string name, output int lat);
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        while (!bus_if.Done && lat < 200) begin
            if (bus_if.Busy) busy_cnt++;
            @(posedge Clock);
            #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(LAT));
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(LAT));
        chk({name, "_busy_at_done"}, 32'(bus_if.Busy), 32'd0);
    endtask

    task automatic chk_result(input string name, input logic [31:0] q,
                              input logic [31:0] r, input logic dz);
        chk({name, "_q"}, bus_if.Quotient, q);
        chk({name, "_r"}, bus_if.Remainder, r);
        chk({name, "_dz"}, 32'(bus_if.DivByZero), 32'(dz));
    endtask

    int lat;

    initial begin
        checks = 0;
        errors = 0;
        bus_if.Start  = 1'b0;
        bus_if.Signed = 1'b0;
        bus_if.DataA  = '0;
        bus_if.DataB  = '0;

        vecs[0] = '{"u_100_7",      1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{"s_m7_2",       1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[2] = '{"u_m7_2",       1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
        vecs[3] = '{"s_div0",       1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1};
        vecs[4] = '{"s_6_3",        1'b1, 32'd6,          32'd3,          32'd2,          32'd0,          1'b0};
        vecs[5] = '{"s_overflow",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vecs[6] = '{"u_div0",       1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
        vecs[7] = '{"s_m100_7",     1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        vecs[8] = '{"s_100_m7",     1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
        vecs[9] = '{"u_max_1",      1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};

        ResetN = 1'b0;
        #1;
        chk("rst_busy", 32'(bus_if.Busy), 32'd0);
        chk("rst_done", 32'(bus_if.Done), 32'd0);
        chk("rst_q", bus_if.Quotient, 32'd0);
        chk("rst_r", bus_if.Remainder, 32'd0);
        chk("rst_dz", 32'(bus_if.DivByZero), 32'd0);
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
            chk({vecs[i].name, "_busy_after_start"}, 32'(bus_if.Busy), 32'd1);
            wait_done(vecs[i].name, lat);
            chk_result(vecs[i].name, vecs[i].q, vecs[i].r, vecs[i].dz);
            @(posedge Clock);
            #1;
            chk({vecs[i].name, "_done_pulse"}, 32'(bus_if.Done), 32'd0);
        end

        // Start pulsed mid-operation with other operands must be ignored.
        issue(1'b0, 32'd100, 32'd7);
        repeat (4) @(posedge Clock);
        #1;
        issue(1'b1, 32'd9, 32'd4);
        lat = 0;
        while (!bus_if.Done && lat < 200) begin
            @(posedge Clock);
            #1;
            lat++;
        end
        chk("ignore_latency", 32'(lat + 5), 32'(LAT));
        chk_result("ignore", 32'd14, 32'd2, 1'b0);

        // Start in the Done cycle is accepted: back-to-back operations.
        issue(1'b0, 32'd6, 32'd3);
        wait_done("b2b_first", lat);
        chk_result("b2b_first", 32'd2, 32'd0, 1'b0);
        bus_if.Start  = 1'b1;
        bus_if.Signed = 1'b0;
        bus_if.DataA  = 32'd50;
        bus_if.DataB  = 32'd8;
        @(posedge Clock);
        #1;
        bus_if.Start = 1'b0;
        chk("b2b_busy_after_start", 32'(bus_if.Busy), 32'd1);
        wait_done("b2b_second", lat);
        chk_result("b2b_second", 32'd6, 32'd2, 1'b0);

        // Asynchronous reset at cycle 10 aborts without a Done pulse.
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge Clock);
        #2;
        ResetN = 1'b0;
        #1;
        chk("abort_busy", 32'(bus_if.Busy), 32'd0);
        chk("abort_done", 32'(bus_if.Done), 32'd0);
        chk("abort_q", bus_if.Quotient, 32'd0);
        chk("abort_r", bus_if.Remainder, 32'd0);
        chk("abort_dz", 32'(bus_if.DivByZero), 32'd0);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge Clock);
            #1;
            if (bus_if.Done) lat++;
        end
        chk("abort_no_done", 32'(lat), 32'd0);
        @(negedge Clock);
        ResetN = 1'b1;
        issue(1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done("after_reset", lat);
        chk_result("after_reset", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge Clock) begin
        if (bus_if.Busy && bus_if.Done) begin
            checks++;
            errors++;
            $display("FAIL busy_done_overlap: got Busy=1 Done=1, expected not both");
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
